// File: rtl/color_mask_localizer.sv
// color_mask_localizer: end-of-chain consumer for the {valid, red, green}
// color-mask pixel stream. Tracks raster position and accumulates a
// bounding box and pixel count per color. At the last pixel of each frame
// it publishes registered results and pulses frame_done for one cycle.
// Optional feature: define LOCALIZER_CENTER_EN to add the center_col and
// center_row outputs, which hold the bbox midpoint of each found color.
module color_mask_localizer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int COLORS     = 2,
  parameter int COORD_W    = 13,
  parameter int COUNT_W    = 19,
  parameter int MIN_PIXELS = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [COLORS:0]            mask_in,
  input  logic                       frame_sync,
  output logic [COLORS*COORD_W-1:0]  bbox_min_col,
  output logic [COLORS*COORD_W-1:0]  bbox_max_col,
  output logic [COLORS*COORD_W-1:0]  bbox_min_row,
  output logic [COLORS*COORD_W-1:0]  bbox_max_row,
  output logic [COLORS*COUNT_W-1:0]  pixel_count,
  output logic [COLORS-1:0]          found,
  output logic                       frame_done,
  output logic [COORD_W-1:0]         cur_col,
  output logic [COORD_W-1:0]         cur_row
`ifdef LOCALIZER_CENTER_EN
  ,
  output logic [COLORS*COORD_W-1:0]  center_col,
  output logic [COLORS*COORD_W-1:0]  center_row
`endif
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(HEIGHT - 1);
  localparam logic [COUNT_W-1:0] MIN_CNT  = COUNT_W'(MIN_PIXELS);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  logic accept;
  logic last_pix;

  logic [COUNT_W-1:0] acc_cnt     [COLORS];
  logic [COORD_W-1:0] acc_min_col [COLORS];
  logic [COORD_W-1:0] acc_max_col [COLORS];
  logic [COORD_W-1:0] acc_min_row [COLORS];
  logic [COORD_W-1:0] acc_max_row [COLORS];
  logic [COLORS-1:0]  acc_empty;

  logic [COUNT_W-1:0] nxt_cnt     [COLORS];
  logic [COORD_W-1:0] nxt_min_col [COLORS];
  logic [COORD_W-1:0] nxt_max_col [COLORS];
  logic [COORD_W-1:0] nxt_min_row [COLORS];
  logic [COORD_W-1:0] nxt_max_row [COLORS];
  logic [COLORS-1:0]  nxt_empty;
  logic [COLORS-1:0]  nxt_found;

  // frame_sync discards any pixel arriving with it
  assign accept   = mask_in[COLORS] && !frame_sync;
  assign last_pix = accept && (cur_col == LAST_COL) && (cur_row == LAST_ROW);

  // Merge the current pixel into each color's accumulator (next-state view)
  always_comb begin
    nxt_empty = acc_empty;
    nxt_found = '0;
    for (int c = 0; c < COLORS; c++) begin
      nxt_cnt[c]     = acc_cnt[c];
      nxt_min_col[c] = acc_min_col[c];
      nxt_max_col[c] = acc_max_col[c];
      nxt_min_row[c] = acc_min_row[c];
      nxt_max_row[c] = acc_max_row[c];
      if (accept && mask_in[c]) begin
        if (acc_cnt[c] != CNT_MAX) begin
          nxt_cnt[c] = acc_cnt[c] + 1'b1;
        end
        if (acc_empty[c]) begin
          nxt_min_col[c] = cur_col;
          nxt_max_col[c] = cur_col;
          nxt_min_row[c] = cur_row;
          nxt_max_row[c] = cur_row;
          nxt_empty[c]   = 1'b0;
        end else begin
          if (cur_col < acc_min_col[c]) nxt_min_col[c] = cur_col;
          if (cur_col > acc_max_col[c]) nxt_max_col[c] = cur_col;
          if (cur_row < acc_min_row[c]) nxt_min_row[c] = cur_row;
          if (cur_row > acc_max_row[c]) nxt_max_row[c] = cur_row;
        end
      end
      nxt_found[c] = (nxt_cnt[c] >= MIN_CNT);
    end
  end

`ifdef LOCALIZER_CENTER_EN
  logic [COORD_W-1:0] nxt_center_col [COLORS];
  logic [COORD_W-1:0] nxt_center_row [COLORS];

  // Midpoint of the merged bbox, summed one bit wider so it cannot overflow
  always_comb begin
    for (int c = 0; c < COLORS; c++) begin
      nxt_center_col[c] = COORD_W'(({1'b0, nxt_min_col[c]} + {1'b0, nxt_max_col[c]}) >> 1);
      nxt_center_row[c] = COORD_W'(({1'b0, nxt_min_row[c]} + {1'b0, nxt_max_row[c]}) >> 1);
    end
  end
`endif

  // Raster position of the next accepted pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (frame_sync) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (accept) begin
      if (cur_col == LAST_COL) begin
        cur_col <= '0;
        cur_row <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
      end else begin
        cur_col <= cur_col + 1'b1;
      end
    end
  end

  // Accumulators: cleared by sync or frame end, otherwise follow merged values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_empty <= '1;
      for (int c = 0; c < COLORS; c++) begin
        acc_cnt[c]     <= '0;
        acc_min_col[c] <= '0;
        acc_max_col[c] <= '0;
        acc_min_row[c] <= '0;
        acc_max_row[c] <= '0;
      end
    end else if (frame_sync || last_pix) begin
      acc_empty <= '1;
      for (int c = 0; c < COLORS; c++) begin
        acc_cnt[c]     <= '0;
        acc_min_col[c] <= '0;
        acc_max_col[c] <= '0;
        acc_min_row[c] <= '0;
        acc_max_row[c] <= '0;
      end
    end else if (accept) begin
      acc_empty <= nxt_empty;
      for (int c = 0; c < COLORS; c++) begin
        acc_cnt[c]     <= nxt_cnt[c];
        acc_min_col[c] <= nxt_min_col[c];
        acc_max_col[c] <= nxt_max_col[c];
        acc_min_row[c] <= nxt_min_row[c];
        acc_max_row[c] <= nxt_max_row[c];
      end
    end
  end

  // Publish results on the last pixel edge; they hold until the next frame end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done   <= 1'b0;
      found        <= '0;
      pixel_count  <= '0;
      bbox_min_col <= '0;
      bbox_max_col <= '0;
      bbox_min_row <= '0;
      bbox_max_row <= '0;
`ifdef LOCALIZER_CENTER_EN
      center_col   <= '0;
      center_row   <= '0;
`endif
    end else begin
      frame_done <= last_pix;
      if (last_pix) begin
        found <= nxt_found;
        for (int c = 0; c < COLORS; c++) begin
          pixel_count[c*COUNT_W +: COUNT_W]  <= nxt_cnt[c];
          bbox_min_col[c*COORD_W +: COORD_W] <= nxt_found[c] ? nxt_min_col[c] : '0;
          bbox_max_col[c*COORD_W +: COORD_W] <= nxt_found[c] ? nxt_max_col[c] : '0;
          bbox_min_row[c*COORD_W +: COORD_W] <= nxt_found[c] ? nxt_min_row[c] : '0;
          bbox_max_row[c*COORD_W +: COORD_W] <= nxt_found[c] ? nxt_max_row[c] : '0;
`ifdef LOCALIZER_CENTER_EN
          center_col[c*COORD_W +: COORD_W]   <= nxt_found[c] ? nxt_center_col[c] : '0;
          center_row[c*COORD_W +: COORD_W]   <= nxt_found[c] ? nxt_center_row[c] : '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_color_mask_localizer.sv
// tb_color_mask_localizer: drives two localizers (MIN_PIXELS=2 and =1, both
// with 5-bit counters) from one pixel stream on an 8x6 raster and compares
// them every cycle against a frame-level model that recomputes each color's
// bbox and count from a stored hit map once the frame completes.
`timescale 1ns/100ps
module tb_color_mask_localizer;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int C  = 2;
  localparam int CW = 13;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [C:0]    mask_in = '0;
  logic          frame_sync = 1'b0;

  logic [C*CW-1:0] bbox_min_col_a, bbox_max_col_a, bbox_min_row_a, bbox_max_row_a;
  logic [C*NW-1:0] pixel_count_a;
  logic [C-1:0]    found_a;
  logic            frame_done_a;
  logic [CW-1:0]   cur_col_a, cur_row_a;
  logic [C*CW-1:0] bbox_min_col_b, bbox_max_col_b, bbox_min_row_b, bbox_max_row_b;
  logic [C*NW-1:0] pixel_count_b;
  logic [C-1:0]    found_b;
  logic            frame_done_b;
  logic [CW-1:0]   cur_col_b, cur_row_b;
`ifdef LOCALIZER_CENTER_EN
  logic [C*CW-1:0] center_col_a, center_row_a, center_col_b, center_row_b;
`endif

  always #5 clk = ~clk;

  color_mask_localizer #(.WIDTH(W), .HEIGHT(H), .COLORS(C), .COORD_W(CW),
                         .COUNT_W(NW), .MIN_PIXELS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .mask_in(mask_in), .frame_sync(frame_sync),
    .bbox_min_col(bbox_min_col_a), .bbox_max_col(bbox_max_col_a),
    .bbox_min_row(bbox_min_row_a), .bbox_max_row(bbox_max_row_a),
    .pixel_count(pixel_count_a), .found(found_a), .frame_done(frame_done_a),
    .cur_col(cur_col_a), .cur_row(cur_row_a)
`ifdef LOCALIZER_CENTER_EN
    , .center_col(center_col_a), .center_row(center_row_a)
`endif
  );

  color_mask_localizer #(.WIDTH(W), .HEIGHT(H), .COLORS(C), .COORD_W(CW),
                         .COUNT_W(NW), .MIN_PIXELS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .mask_in(mask_in), .frame_sync(frame_sync),
    .bbox_min_col(bbox_min_col_b), .bbox_max_col(bbox_max_col_b),
    .bbox_min_row(bbox_min_row_b), .bbox_max_row(bbox_max_row_b),
    .pixel_count(pixel_count_b), .found(found_b), .frame_done(frame_done_b),
    .cur_col(cur_col_b), .cur_row(cur_row_b)
`ifdef LOCALIZER_CENTER_EN
    , .center_col(center_col_b), .center_row(center_row_b)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: hit map of the frame in progress and held results
  bit hit [C][H][W];
  int m_col, m_row;
  int e_cnt [C];
  int e_minc [C], e_maxc [C], e_minr [C], e_maxr [C];
  bit e_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearFrame();
    for (int c = 0; c < C; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++)
          hit[c][r][x] = 1'b0;
  endtask

  task automatic modelReset();
    clearFrame();
    m_col  = 0;
    m_row  = 0;
    e_done = 1'b0;
    for (int c = 0; c < C; c++) begin
      e_cnt[c] = 0; e_minc[c] = 0; e_maxc[c] = 0; e_minr[c] = 0; e_maxr[c] = 0;
    end
  endtask

  // Whole-frame summary: count flagged pixels and take extremes of positions
  task automatic finishFrame();
    for (int c = 0; c < C; c++) begin
      int n, mnc, mxc, mnr, mxr;
      n = 0; mnc = W; mxc = -1; mnr = H; mxr = -1;
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++)
          if (hit[c][r][x]) begin
            n++;
            if (x < mnc) mnc = x;
            if (x > mxc) mxc = x;
            if (r < mnr) mnr = r;
            if (r > mxr) mxr = r;
          end
      e_cnt[c]  = (n > 31) ? 31 : n;
      e_minc[c] = (n == 0) ? 0 : mnc;
      e_maxc[c] = (n == 0) ? 0 : mxc;
      e_minr[c] = (n == 0) ? 0 : mnr;
      e_maxr[c] = (n == 0) ? 0 : mxr;
    end
  endtask

  task automatic modelEdge(input bit v, input bit r, input bit g, input bit s);
    e_done = 1'b0;
    if (s) begin
      clearFrame();
      m_col = 0;
      m_row = 0;
    end else if (v) begin
      if (r) hit[1][m_row][m_col] = 1'b1;
      if (g) hit[0][m_row][m_col] = 1'b1;
      if (m_col == W-1 && m_row == H-1) begin
        finishFrame();
        e_done = 1'b1;
        clearFrame();
        m_col = 0;
        m_row = 0;
      end else if (m_col == W-1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      int thr;
      logic [C*CW-1:0] mnc, mxc, mnr, mxr, cc, cr;
      logic [C*NW-1:0] cnt;
      logic [C-1:0]    fnd;
      string sfx;
      thr = (k == 0) ? 2 : 1;
      sfx = (k == 0) ? "a" : "b";
      for (int c = 0; c < C; c++) begin
        bit f;
        f = (e_cnt[c] >= thr);
        fnd[c] = f;
        cnt[c*NW +: NW] = NW'(e_cnt[c]);
        mnc[c*CW +: CW] = f ? CW'(e_minc[c]) : '0;
        mxc[c*CW +: CW] = f ? CW'(e_maxc[c]) : '0;
        mnr[c*CW +: CW] = f ? CW'(e_minr[c]) : '0;
        mxr[c*CW +: CW] = f ? CW'(e_maxr[c]) : '0;
        cc[c*CW +: CW]  = f ? CW'((e_minc[c] + e_maxc[c]) / 2) : '0;
        cr[c*CW +: CW]  = f ? CW'((e_minr[c] + e_maxr[c]) / 2) : '0;
      end
      check({"cur_col_", sfx},    (k == 0) ? cur_col_a : cur_col_b, CW'(m_col));
      check({"cur_row_", sfx},    (k == 0) ? cur_row_a : cur_row_b, CW'(m_row));
      check({"frame_done_", sfx}, (k == 0) ? frame_done_a : frame_done_b, e_done);
      check({"found_", sfx},      (k == 0) ? found_a : found_b, fnd);
      check({"count_", sfx},      (k == 0) ? pixel_count_a : pixel_count_b, cnt);
      check({"min_col_", sfx},    (k == 0) ? bbox_min_col_a : bbox_min_col_b, mnc);
      check({"max_col_", sfx},    (k == 0) ? bbox_max_col_a : bbox_max_col_b, mxc);
      check({"min_row_", sfx},    (k == 0) ? bbox_min_row_a : bbox_min_row_b, mnr);
      check({"max_row_", sfx},    (k == 0) ? bbox_max_row_a : bbox_max_row_b, mxr);
`ifdef LOCALIZER_CENTER_EN
      check({"center_col_", sfx}, (k == 0) ? center_col_a : center_col_b, cc);
      check({"center_row_", sfx}, (k == 0) ? center_row_a : center_row_b, cr);
`endif
    end
  endtask

  // One clock of stimulus: drive at the falling edge, check 1 ns after rising
  task automatic applyStimulus(input bit v, input bit r, input bit g, input bit s);
    mask_in    = {v, r, g};
    frame_sync = s;
    @(posedge clk);
    modelEdge(v, r, g, s);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // mode 0 random, 1 red block, 2 last pixel red only, 3 all red and green
  task automatic runFrame(input int mode, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      int row, col;
      bit r, g;
      row = i / W;
      col = i % W;
      case (mode)
        0:       begin r = 1'($urandom_range(0, 1)); g = 1'($urandom_range(0, 1)); end
        1:       begin r = (row >= 2 && row <= 3 && col >= 3 && col <= 5); g = 1'b0; end
        2:       begin r = (i == W*H-1); g = 1'b0; end
        default: begin r = 1'b1; g = 1'b1; end
      endcase
      if (gaps) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      applyStimulus(1'b1, r, g, 1'b0);
    end
  endtask

  task automatic runPartial(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic checkRedBlock();
    check("blk frame_done",  frame_done_a, 1'b1);
    check("blk red min_col", bbox_min_col_a[CW +: CW], 3);
    check("blk red max_col", bbox_max_col_a[CW +: CW], 5);
    check("blk red min_row", bbox_min_row_a[CW +: CW], 2);
    check("blk red max_row", bbox_max_row_a[CW +: CW], 3);
    check("blk count",       pixel_count_a, {5'd6, 5'd0});
    check("blk found",       found_a, 2'b10);
    check("blk green bbox",  bbox_max_col_a[0 +: CW], 0);
`ifdef LOCALIZER_CENTER_EN
    check("blk red center_col", center_col_a[CW +: CW], 4);
    check("blk red center_row", center_row_a[CW +: CW], 2);
`endif
  endtask

  initial begin
    $display("[TB] start");
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] red block, continuous valid");
    runFrame(1, 1'b0);
    checkRedBlock();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check("blk done one cycle", frame_done_a, 1'b0);

    $display("[TB] red block, valid every other cycle");
    runFrame(1, 1'b1);
    checkRedBlock();

    $display("[TB] single red pixel at last position");
    runFrame(2, 1'b0);
    check("single found_a",    found_a, 2'b00);
    check("single count_a",    pixel_count_a[NW +: NW], 1);
    check("single min_col_a",  bbox_min_col_a[CW +: CW], 0);
    check("single found_b",    found_b, 2'b10);
    check("single min_col_b",  bbox_min_col_b[CW +: CW], 7);
    check("single max_col_b",  bbox_max_col_b[CW +: CW], 7);
    check("single min_row_b",  bbox_min_row_b[CW +: CW], 5);
    check("single max_row_b",  bbox_max_row_b[CW +: CW], 5);

    $display("[TB] frame_sync at row 3 col 2 with valid red pixel");
    runPartial(3*W + 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check("sync cur_col", cur_col_a, 0);
    check("sync cur_row", cur_row_a, 0);
    runFrame(0, 1'b0);

    $display("[TB] asynchronous reset mid-frame");
    runPartial(20);
    mask_in = '0;
    #2 reset_n = 1'b0;
    #0.5;
    modelReset();
    checkOutput();
    #0.5 reset_n = 1'b1;
    @(negedge clk);
    runFrame(0, 1'b0);

    $display("[TB] full frame of red and green, counter saturation");
    runFrame(3, 1'b0);
    check("sat count", pixel_count_a, {5'd31, 5'd31});
    check("sat found", found_a, 2'b11);
    check("sat max_col", bbox_max_col_a, {13'd7, 13'd7});
    check("sat max_row", bbox_max_row_a, {13'd5, 13'd5});

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) runFrame(0, f[0]);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
